// File: rtl/mul_add_seq_if.sv
// mul_add_seq_if: handshake bundle for the neuron MAC block.
// slave = the block (beats/bias in, RESULT out); master = the driver.
interface mul_add_seq_if #(
  parameter int N_NEURON = 46,
  parameter int DW       = 8,
  parameter int ACC_W    = 32
);
  logic                      START;
  logic                      IN_VALID;
  logic                      IN_READY;
  logic [DW-1:0]             IN_PIX;
  logic [N_NEURON*DW-1:0]    IN_W;
  logic [N_NEURON*DW-1:0]    BIAS;
  logic                      OUT_VALID;
  logic                      OUT_READY;
  logic [N_NEURON*ACC_W-1:0] RESULT;
  logic                      BUSY;

  modport master (
    output START, IN_VALID, IN_PIX, IN_W, BIAS, OUT_READY,
    input  IN_READY, OUT_VALID, RESULT, BUSY
  );

  modport slave (
    input  START, IN_VALID, IN_PIX, IN_W, BIAS, OUT_READY,
    output IN_READY, OUT_VALID, RESULT, BUSY
  );
endinterface

// File: rtl/mul_add_seq.sv
// mul_add_seq: per-neuron multiply-accumulate over N_INPUT pixel beats,
// then one bias add; RESULT held until taken. Ports: CLK, RESET, bus.
// Macro MUL_ADD_SAT_EN: saturating accumulators (default: wrap).
module mul_add_seq #(
  parameter int N_NEURON = 46,
  parameter int N_INPUT  = 784,
  parameter int DW       = 8,
  parameter int ACC_W    = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  mul_add_seq_if.slave bus
);

  localparam int CW = $clog2(N_INPUT + 1);
  localparam int PW = 2 * DW + 1;
  // one guard bit above the wider of product/accumulator
  localparam int EW = ((ACC_W > PW) ? ACC_W : PW) + 1;

  localparam logic signed [EW-1:0] SMAX =
    {{(EW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN =
    {{(EW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_BIAS  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] acc    [N_NEURON];
  logic [ACC_W-1:0] acc_nx [N_NEURON];
  logic             beat;
  logic             last;

  function automatic logic signed [EW-1:0] prod_of(
    input logic [DW-1:0] pix,
    input logic [DW-1:0] w
  );
    logic signed [PW-1:0] p;
    p = $signed({1'b0, pix}) * $signed(w);
    return EW'(p);
  endfunction

  function automatic logic [ACC_W-1:0] upd(
    input logic [ACC_W-1:0]     a,
    input logic signed [EW-1:0] t
  );
    logic signed [EW-1:0] s;
    s = EW'($signed(a)) + t;
`ifdef MUL_ADD_SAT_EN
    if (s > SMAX)
      return SMAX[ACC_W-1:0];
    else if (s < SMIN)
      return SMIN[ACC_W-1:0];
    else
      return s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

  assign beat = (state == S_ACCUM) && bus.IN_VALID;
  assign last = (cnt == CW'(N_INPUT - 1));

  always_comb begin
    for (int k = 0; k < N_NEURON; k++) begin
      acc_nx[k] = acc[k];
      if (state == S_BIAS)
        acc_nx[k] = upd(acc[k],
          EW'($signed(bus.BIAS[k*DW +: DW])));
      else if (beat)
        acc_nx[k] = upd(acc[k],
          prod_of(bus.IN_PIX, bus.IN_W[k*DW +: DW]));
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      cnt   <= '0;
      for (int k = 0; k < N_NEURON; k++)
        acc[k] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.START) begin
            cnt   <= '0;
            state <= S_ACCUM;
            for (int k = 0; k < N_NEURON; k++)
              acc[k] <= '0;
          end
        end
        S_ACCUM: begin
          if (bus.IN_VALID) begin
            cnt <= cnt + CW'(1);
            for (int k = 0; k < N_NEURON; k++)
              acc[k] <= acc_nx[k];
            if (last)
              state <= S_BIAS;
          end
        end
        S_BIAS: begin
          for (int k = 0; k < N_NEURON; k++)
            acc[k] <= acc_nx[k];
          state <= S_DONE;
        end
        default: begin
          if (bus.OUT_READY)
            state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.IN_READY  = (state == S_ACCUM);
  assign bus.OUT_VALID = (state == S_DONE);
  assign bus.BUSY      = (state != S_IDLE);

  always_comb begin
    bus.RESULT = '0;
    for (int k = 0; k < N_NEURON; k++)
      bus.RESULT[k*ACC_W +: ACC_W] = acc[k];
  end

endmodule

// File: tb/tb_mul_add_seq.sv
// tb_mul_add_seq: scoreboard bench for mul_add_seq with an integer
// reference model; directed vectors plus randomized images.
module tb_mul_add_seq;

  localparam int NN = 2;
  localparam int NI = 4;
  localparam int DW = 8;
  localparam int AW = 12;

  typedef logic [NN*AW-1:0] res_t;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  mul_add_seq_if #(.N_NEURON(NN), .DW(DW), .ACC_W(AW)) bus ();

  mul_add_seq #(
    .N_NEURON(NN), .N_INPUT(NI), .DW(DW), .ACC_W(AW)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus.slave)
  );

  res_t exp_q[$];
  res_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  int pix[NI];
  int wt[NI][NN];
  int bs[NN];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // two's complement wrap or clamp to the ACC_W range
  function automatic longint fold(input longint v);
    longint m;
    longint hi;
    m  = longint'(1) <<< AW;
    hi = (longint'(1) <<< (AW - 1)) - 1;
`ifdef MUL_ADD_SAT_EN
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
`else
    v = v % m;
    if (v < 0) v += m;
    if (v > hi) v -= m;
    return v;
`endif
  endfunction

  function automatic res_t model();
    longint a[NN];
    res_t   r;
    for (int k = 0; k < NN; k++) a[k] = 0;
    for (int i = 0; i < NI; i++)
      for (int k = 0; k < NN; k++)
        a[k] = fold(a[k] + longint'(pix[i]) * longint'(wt[i][k]));
    for (int k = 0; k < NN; k++)
      a[k] = fold(a[k] + longint'(bs[k]));
    r = '0;
    for (int k = 0; k < NN; k++)
      r[k*AW +: AW] = a[k][AW-1:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_beat(input int i);
    bus.IN_PIX = pix[i][DW-1:0];
    for (int k = 0; k < NN; k++)
      bus.IN_W[k*DW +: DW] = wt[i][k][DW-1:0];
  endtask

  task automatic run_image(input int abort_after,
                           input bit gaps,
                           input int out_stall,
                           input bit noise);
    res_t e;
    e = model();
    for (int k = 0; k < NN; k++)
      bus.BIAS[k*DW +: DW] = bs[k][DW-1:0];
    if (abort_after < 0) exp_q.push_back(e);
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check("busy_after_start", bus.BUSY, 1);
    check("ready_in_accum", bus.IN_READY, 1);
    for (int i = 0; i < NI; i++) begin
      if (abort_after == i) begin
        RESET = 1'b1;
        bus.IN_VALID = 1'b0;
        #1;
        check("abort_in_ready", bus.IN_READY, 0);
        check("abort_out_valid", bus.OUT_VALID, 0);
        check("abort_busy", bus.BUSY, 0);
        check("abort_result", bus.RESULT, 0);
        tick();
        RESET = 1'b0;
        tick();
        return;
      end
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.IN_VALID = 1'b0;
          bus.IN_PIX = DW'($urandom);
          bus.START = noise;
          tick();
        end
      end
      bus.IN_VALID = 1'b1;
      set_beat(i);
      bus.START = noise && (i == 1);
      tick();
    end
    bus.IN_VALID = 1'b0;
    bus.START = 1'b0;
    check("ready_low_bias", bus.IN_READY, 0);
    check("valid_low_bias", bus.OUT_VALID, 0);
    tick();
    check("valid_rise", bus.OUT_VALID, 1);
    repeat (out_stall) begin
      bus.START = noise;
      tick();
      check("stall_valid", bus.OUT_VALID, 1);
      check("stall_result", bus.RESULT, e);
    end
    bus.OUT_READY = 1'b1;
    bus.START = noise;
    tick();
    bus.OUT_READY = 1'b0;
    bus.START = 1'b0;
    check("idle_after_take", bus.BUSY, 0);
    check("valid_drop", bus.OUT_VALID, 0);
    check("result_retained", bus.RESULT, e);
    tick();
  endtask

  always @(negedge CLK) begin
    if (bus.OUT_VALID === 1'b1 && exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL spurious_out_valid: got 1 want 0");
    end else if (bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b1) begin
      mon_e = exp_q.pop_front();
      check("sb_result", bus.RESULT, mon_e);
    end
  end

  task automatic rand_data();
    for (int i = 0; i < NI; i++) begin
      pix[i] = int'($urandom_range(0, 255));
      for (int k = 0; k < NN; k++)
        wt[i][k] = int'($urandom_range(0, 255)) - 128;
    end
    for (int k = 0; k < NN; k++)
      bs[k] = int'($urandom_range(0, 255)) - 128;
  endtask

  initial begin
    res_t k;
    RESET = 1'b1;
    bus.START = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.IN_PIX = '0;
    bus.IN_W = '0;
    bus.BIAS = '0;
    bus.OUT_READY = 1'b0;
    #1;
    check("rst_in_ready", bus.IN_READY, 0);
    check("rst_out_valid", bus.OUT_VALID, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_result", bus.RESULT, 0);
    tick();
    tick();
    RESET = 1'b0;
    tick();
    check("idle_busy", bus.BUSY, 0);

    for (int i = 0; i < NI; i++) begin
      pix[i] = i + 1;
      wt[i][0] = 1;
      wt[i][1] = -2;
    end
    bs[0] = 5;
    bs[1] = -3;
    run_image(-1, 1'b0, 0, 1'b0);
    k = {12'hFE9, 12'h00F};
    check("basic_const", bus.RESULT, k);
    run_image(-1, 1'b1, 0, 1'b0);
    check("gaps_const", bus.RESULT, k);
    run_image(-1, 1'b1, 10, 1'b1);
    check("noise_const", bus.RESULT, k);

    rand_data();
    run_image(2, 1'b0, 0, 1'b0);
    rand_data();
    run_image(-1, 1'b0, 2, 1'b0);

    for (int i = 0; i < NI; i++) begin
      pix[i] = 255;
      wt[i][0] = 127;
      wt[i][1] = -128;
    end
    bs[0] = 0;
    bs[1] = 0;
    run_image(-1, 1'b0, 0, 1'b0);
`ifdef MUL_ADD_SAT_EN
    k = {12'h800, 12'h7FF};
`else
    k = {12'h200, 12'hA04};
`endif
    check("overflow_const", bus.RESULT, k);

    repeat (20) begin
      rand_data();
      run_image(-1, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end

    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
